// File: rtl/risc_pkg.sv
// Shared definitions for the fetch front end: next-PC source codes and
// sequencer FSM states.
package risc_pkg;

    // Codes are ordered by redirect priority, so a plain magnitude compare
    // picks the winner between two sources.
    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_EXC = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-request bundle between the PC sequencer and its
// surroundings (pipeline redirect sources and instruction memory).
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             exc;
    logic             imem_ready;
    logic [WIDTH-1:0] pc;
    logic             imem_req;
    logic [1:0]       sel;
    logic             redirect_pending;

    modport master (
        output stall, br_taken, br_target, jump, jump_target, exc, imem_ready,
        input  pc, imem_req, sel, redirect_pending
    );

    modport slave (
        input  stall, br_taken, br_target, jump, jump_target, exc, imem_ready,
        output pc, imem_req, sel, redirect_pending
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational redirect resolution: picks the winning same-cycle request,
// then arbitrates it against the latched redirect to form the next PC.
module pc_next_sel
    import risc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
    input  sel_e             lat_sel,
    input  logic [WIDTH-1:0] lat_target,
    output sel_e             new_sel,
    output logic [WIDTH-1:0] new_target,
    output sel_e             next_sel,
    output logic [WIDTH-1:0] next_pc
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    logic [WIDTH-1:0] next_target;

    // NOTE: every output of a combinational block gets a default up front;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        new_sel    = SEL_SEQ;
        new_target = '0;
        if (exc) begin
            new_sel    = SEL_EXC;
            new_target = EXC_VECTOR & ALIGN_MASK;
        end else if (jump) begin
            new_sel    = SEL_JMP;
            new_target = jump_target & ALIGN_MASK;
        end else if (br_taken) begin
            new_sel    = SEL_BR;
            new_target = br_target & ALIGN_MASK;
        end

        // An empty latch holds SEL_SEQ, so any real request beats it.
        if (new_sel > lat_sel) begin
            next_sel    = new_sel;
            next_target = new_target;
        end else begin
            next_sel    = lat_sel;
            next_target = lat_target;
        end

        next_pc = (next_sel == SEL_SEQ) ? pc + WIDTH'(4) : next_target;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/FETCH/WAIT handshake with instruction memory and a
// one-entry priority latch for redirects that arrive between acceptances.
module pc_sequencer
    import risc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_sequencer_if.slave        bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    sel_e             lat_sel_q, lat_sel_d;
    logic [WIDTH-1:0] lat_target_q, lat_target_d;

    sel_e             new_sel, next_sel;
    logic [WIDTH-1:0] new_target, next_pc;
    logic             imem_req, accept;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc          (pc_q),
        .br_taken    (bus.br_taken),
        .br_target   (bus.br_target),
        .jump        (bus.jump),
        .jump_target (bus.jump_target),
        .exc         (bus.exc),
        .lat_sel     (lat_sel_q),
        .lat_target  (lat_target_q),
        .new_sel     (new_sel),
        .new_target  (new_target),
        .next_sel    (next_sel),
        .next_pc     (next_pc)
    );

    always_comb begin
        imem_req     = !reset && (state_q != ST_BOOT) && !bus.stall;
        accept       = imem_req && bus.imem_ready;
        state_d      = state_q;
        pc_d         = pc_q;
        lat_sel_d    = lat_sel_q;
        lat_target_d = lat_target_q;

        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            default: if (imem_req) state_d = accept ? ST_FETCH : ST_WAIT;
        endcase

        if (accept) begin
            pc_d         = next_pc;
            lat_sel_d    = SEL_SEQ;
            lat_target_d = '0;
        end else if (new_sel > lat_sel_q) begin
            // Only a strictly higher-priority request displaces the latch.
            lat_sel_d    = new_sel;
            lat_target_d = new_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            lat_sel_q    <= SEL_SEQ;
            lat_target_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            lat_sel_q    <= lat_sel_d;
            lat_target_q <= lat_target_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.imem_req         = imem_req;
    assign bus.sel              = reset ? SEL_SEQ : next_sel;
    assign bus.redirect_pending = (lat_sel_q != SEL_SEQ);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// all compared against a priority-number model of the fetch rules.
module tb_pc_sequencer;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXV = 32'h0000_0080;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    pc_sequencer_if #(.WIDTH(32)) ifc ();

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EXV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Model: priority numbers 0 (none), 1 branch, 2 jump, 3 exception.
    logic [31:0] m_pc;
    bit          m_boot;
    int          m_pri;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit rdy,
                         input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt, input bit ex);
        reset           = rst;
        ifc.stall       = st;
        ifc.imem_ready  = rdy;
        ifc.br_taken    = br;
        ifc.br_target   = bt;
        ifc.jump        = jp;
        ifc.jump_target = jt;
        ifc.exc         = ex;
    endtask

    // Check outputs mid-cycle against the model, then advance model and DUT.
    task automatic tick();
        int          cur, best;
        logic [31:0] cur_t, best_t;
        bit          exp_req;
        @(negedge clk);
        cur   = ifc.exc ? 3 : ifc.jump ? 2 : ifc.br_taken ? 1 : 0;
        cur_t = (ifc.exc ? EXV : ifc.jump ? ifc.jump_target : ifc.br_target) & ~32'h3;
        best   = (cur > m_pri) ? cur : m_pri;
        best_t = (cur > m_pri) ? cur_t : m_tgt;
        exp_req = !reset && !m_boot && !ifc.stall;
        check("pc", ifc.pc, m_pc);
        check("imem_req", 32'(ifc.imem_req), 32'(exp_req));
        check("sel", 32'(ifc.sel), reset ? 32'd0 : 32'(best));
        check("redirect_pending", 32'(ifc.redirect_pending), 32'(m_pri != 0));
        @(posedge clk);
        if (reset) begin
            m_pc = RV; m_boot = 1'b1; m_pri = 0; m_tgt = '0;
        end else if (exp_req && ifc.imem_ready) begin
            m_pc  = (best != 0) ? best_t : m_pc + 32'd4;
            m_pri = 0;
        end else begin
            m_boot = 1'b0;
            if (cur > m_pri) begin
                m_pri = cur; m_tgt = cur_t;
            end
        end
        if (!reset && exp_req) m_boot = 1'b0;
        #1;
    endtask

    task automatic cyc(input bit rst, input bit st, input bit rdy,
                       input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input bit ex);
        drive(rst, st, rdy, br, bt, jp, jt, ex);
        tick();
    endtask

    initial begin
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        m_pc = RV; m_boot = 1'b1; m_pri = 0; m_tgt = '0;
        check("reset_pc", ifc.pc, RV);
        check("reset_req", 32'(ifc.imem_req), 32'd0);
        check("reset_sel", 32'(ifc.sel), 32'd0);
        check("reset_pending", 32'(ifc.redirect_pending), 32'd0);

        // Boot then sequential fetch: 0 (boot), 0, 4, 8, C.
        cyc(0, 0, 1, 0, 0, 0, 0, 0); check("boot_hold", ifc.pc, 32'h0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0); check("seq_4", ifc.pc, 32'h4);
        cyc(0, 0, 1, 0, 0, 0, 0, 0); check("seq_8", ifc.pc, 32'h8);
        cyc(0, 0, 1, 0, 0, 0, 0, 0); check("seq_c", ifc.pc, 32'hC);
        cyc(0, 0, 1, 0, 0, 0, 0, 0); check("seq_10", ifc.pc, 32'h10);

        // Branch arriving while memory is busy is latched and applied later.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h44, 0, 0, 0);
        check("wait_pending", 32'(ifc.redirect_pending), 32'd1);
        check("wait_hold", ifc.pc, 32'h10);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("wait_hold2", ifc.pc, 32'h10);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("br_applied", ifc.pc, 32'h44);

        // All three redirects at once: exception wins.
        drive(0, 0, 1, 1, 32'h300, 1, 32'h200, 1);
        #1 check("sel_exc", 32'(ifc.sel), 32'd3);
        tick();
        check("exc_pc", ifc.pc, 32'h80);

        // Latched jump survives a later branch; latched exc beats a later jump.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h200, 0);
        cyc(0, 0, 0, 1, 32'h300, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("jmp_over_br", ifc.pc, 32'h200);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h500, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("exc_over_jmp", ifc.pc, 32'h80);

        // Wrap and target alignment.
        cyc(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0);
        check("jmp_top", ifc.pc, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("wrap", ifc.pc, 32'h0);
        cyc(0, 0, 1, 1, 32'h47, 0, 0, 0);
        check("align", ifc.pc, 32'h44);

        // Reset in WAIT with a pending redirect.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h123, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        check("rst_pc", ifc.pc, RV);
        check("rst_pending", 32'(ifc.redirect_pending), 32'd0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        #1 check("rst_req", 32'(ifc.imem_req), 32'd0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 7) == 0), $urandom,
                ($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: first fetch address after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0080: exception redirect target.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  downstream hold; suppresses fetch requests.
REQ-007 br_taken  input  1  branch redirect request, single-cycle pulse.
REQ-008 br_target  input  WIDTH  branch target, valid with br_taken.
REQ-009 jump  input  1  jump redirect request, single-cycle pulse.
REQ-010 jump_target  input  WIDTH  jump target, valid with jump.
REQ-011 exc  input  1  exception redirect request, single-cycle pulse.
REQ-012 imem_ready  input  1  instruction memory accepts current request.
REQ-013 pc  output  WIDTH  address of current fetch request.
REQ-014 imem_req  output  1  fetch request valid.
REQ-015 sel  output  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 exception.
REQ-016 redirect_pending  output  1  a redirect is latched and not yet applied.

Function
REQ-017 FSM states SHALL be BOOT, FETCH, WAIT.
REQ-018 BOOT SHALL last exactly one cycle, then go to FETCH; imem_req=0 in BOOT.
REQ-019 imem_req SHALL be 1 in FETCH and WAIT when stall=0, and 0 when stall=1.
REQ-020 A request SHALL be accepted in a cycle where imem_req=1 and imem_ready=1.
REQ-021 In FETCH or WAIT, imem_req=1 with imem_ready=0 SHALL go to/stay in WAIT; acceptance SHALL go to FETCH.
REQ-022 pc SHALL change only on acceptance; stall or WAIT SHALL hold pc.
REQ-023 Redirect priority SHALL be exc > jump > br_taken; same-cycle requests resolve to highest.
REQ-024 A redirect not coinciding with acceptance SHALL be latched with its target; redirect_pending=1 from the next cycle.
REQ-025 A later higher-priority redirect SHALL overwrite the latch; equal or lower priority SHALL be dropped.
REQ-026 On acceptance, next pc SHALL be the higher-priority of same-cycle and latched redirect, else pc+4; latch cleared.
REQ-027 pc+4 SHALL wrap modulo 2^WIDTH.
REQ-028 Targets SHALL have bits [1:0] forced to 00 when loaded.
REQ-029 sel SHALL combinationally report the source chosen for the next pc in the current cycle (00 if none).
REQ-030 Redirects SHALL be latched during stall and during BOOT.
REQ-031 Latency: accepted fetch at A SHALL present next address on pc at A+1.

Reset
REQ-032 reset SHALL force state=BOOT, pc=RESET_VECTOR, redirect latch cleared, redirect_pending=0, imem_req=0, sel=00.
REQ-033 reset SHALL override all inputs in the same cycle, including mid-WAIT and with a pending redirect.

Structure
REQ-034 Shared package risc_pkg SHALL hold sel codes (SEL_SEQ, SEL_BR, SEL_JMP, SEL_EXC) and the FSM state enum.
REQ-035 One sub-module, pc_next_sel, SHALL implement combinational priority resolution and target select; FSM and registers stay in pc_sequencer.

Verification
REQ-036 Reset, imem_ready=1 held -> pc 0,0,4,8,C on successive cycles (BOOT then sequential).
REQ-037 pc=0x10, imem_ready=0 for 3 cycles, br_taken target 0x44 in 2nd -> redirect_pending=1, pc holds 0x10, then 0x44 after acceptance.
REQ-038 Same cycle exc, jump 0x200, br_taken 0x300, imem_ready=1 -> sel=11, next pc=0x80.
REQ-039 jump 0x200 latched in WAIT, then br_taken 0x300 -> pc becomes 0x200; latched exc then jump -> 0x80.
REQ-040 pc=0xFFFF_FFFC, accept -> pc=0x0000_0000; br_target 0x47 -> pc=0x44.
REQ-041 reset asserted in WAIT with pending redirect -> pc=RESET_VECTOR, redirect_pending=0, imem_req=0 next cycle.
